// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and width defaults for the fetch/data memory arbiter.
package memory_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, BUSY_INSTR, BUSY_DATA} state_e;
    typedef enum logic {REQ_INSTR, REQ_DATA} req_e;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch, data and shared-memory ports of the arbiter.
interface memory_arbiter_if import memory_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
    logic [ADDR_WIDTH-1:0]   instruction_addr;
    logic                    instruction_fetch_activate;
    logic [DATA_WIDTH-1:0]   instruction_data;
    logic                    instruction_fetch_done;
    logic [ADDR_WIDTH-1:0]   data_addr;
    logic [DATA_WIDTH-1:0]   data_write_data;
    logic                    data_write_enable;
    logic [DATA_WIDTH/8-1:0] data_byte_enable;
    logic                    data_access_activate;
    logic [DATA_WIDTH-1:0]   data_read_data;
    logic                    data_access_done;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_write_data;
    logic                    mem_write_enable;
    logic [DATA_WIDTH/8-1:0] mem_byte_enable;
    logic                    mem_request;
    logic [DATA_WIDTH-1:0]   mem_read_data;
    logic                    mem_done;
    modport slave (
        input  instruction_addr, instruction_fetch_activate,
        output instruction_data, instruction_fetch_done,
        input  data_addr, data_write_data, data_write_enable, data_byte_enable, data_access_activate,
        output data_read_data, data_access_done,
        output mem_addr, mem_write_data, mem_write_enable, mem_byte_enable, mem_request,
        input  mem_read_data, mem_done
    );
    modport master (
        output instruction_addr, instruction_fetch_activate,
        input  instruction_data, instruction_fetch_done,
        output data_addr, data_write_data, data_write_enable, data_byte_enable, data_access_activate,
        input  data_read_data, data_access_done,
        input  mem_addr, mem_write_data, mem_write_enable, mem_byte_enable, mem_request,
        output mem_read_data, mem_done
    );
endinterface

// File: rtl/memory_arbiter_response.sv
// memory_arbiter_response: per-port response latch; done holds only while the port still asks
// for the exact command that was issued on its behalf.
module memory_arbiter_response import memory_arbiter_pkg::*; #(
    parameter int AW       = DEF_ADDR_WIDTH,
    parameter int DW       = DEF_DATA_WIDTH,
    parameter bit CHECK_WE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant_i,
    input  logic          capture_i,
    input  logic          activate_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] mem_data_i,
    output logic          pending_o,
    output logic          done_o,
    output logic [DW-1:0] data_o
);
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d, valid_q, valid_d, match;
    logic [DW-1:0] data_q, data_d;
    assign match     = activate_i && addr_i == addr_q && (!CHECK_WE || we_i == we_q);
    assign done_o    = valid_q && match;
    assign pending_o = activate_i && !done_o;
    assign data_o    = data_q;
    assign addr_d    = grant_i ? addr_i : addr_q;
    assign we_d      = grant_i ? we_i : we_q;
    assign valid_d   = capture_i ? match : valid_q && match;
    assign data_d    = capture_i && match ? mem_data_i : data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between instruction fetch and the data path.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects alternating priority instead of data-over-fetch.
module memory_arbiter import memory_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic clk,
    input logic rst,
    memory_arbiter_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    state_e                state_q;
    logic                  mem_req_q, cmd_we_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [BW-1:0]         cmd_be_q;
    logic                  i_pend, d_pend, pick_data, idle, gnt_instr, gnt_data;
    assign idle = state_q == IDLE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    req_e last_q;
    assign pick_data = d_pend && (!i_pend || last_q == REQ_INSTR);
    always_ff @(posedge clk) begin
        if (rst) last_q <= REQ_INSTR;
        else if (gnt_instr || gnt_data) last_q <= gnt_data ? REQ_DATA : REQ_INSTR;
    end
`else
    assign pick_data = d_pend;
`endif
    assign gnt_data  = idle && pick_data;
    assign gnt_instr = idle && i_pend && !pick_data;
    // mem_* are driven only from the command register captured at grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= '0;
        end else if (idle) begin
            if (gnt_instr || gnt_data) begin
                state_q     <= gnt_data ? BUSY_DATA : BUSY_INSTR;
                mem_req_q   <= 1'b1;
                cmd_addr_q  <= gnt_data ? bus.data_addr : bus.instruction_addr;
                cmd_wdata_q <= gnt_data ? bus.data_write_data : '0;
                cmd_we_q    <= gnt_data && bus.data_write_enable;
                cmd_be_q    <= gnt_data ? bus.data_byte_enable : '0;
            end
        end else if (bus.mem_done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end
    end
    assign bus.mem_addr         = cmd_addr_q;
    assign bus.mem_write_data   = cmd_wdata_q;
    assign bus.mem_write_enable = cmd_we_q;
    assign bus.mem_byte_enable  = cmd_be_q;
    assign bus.mem_request      = mem_req_q;
    memory_arbiter_response #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .CHECK_WE(1'b0)) u_instr_rsp (
        .clk        (clk),
        .rst        (rst),
        .grant_i    (gnt_instr),
        .capture_i  (state_q == BUSY_INSTR && bus.mem_done),
        .activate_i (bus.instruction_fetch_activate),
        .addr_i     (bus.instruction_addr),
        .we_i       (1'b0),
        .mem_data_i (bus.mem_read_data),
        .pending_o  (i_pend),
        .done_o     (bus.instruction_fetch_done),
        .data_o     (bus.instruction_data)
    );
    memory_arbiter_response #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .CHECK_WE(1'b1)) u_data_rsp (
        .clk        (clk),
        .rst        (rst),
        .grant_i    (gnt_data),
        .capture_i  (state_q == BUSY_DATA && bus.mem_done),
        .activate_i (bus.data_access_activate),
        .addr_i     (bus.data_addr),
        .we_i       (bus.data_write_enable),
        .mem_data_i (bus.mem_read_data),
        .pending_o  (d_pend),
        .done_o     (bus.data_access_done),
        .data_o     (bus.data_read_data)
    );
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_arbiter_if bus ();
    memory_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0, n_fail = 0;
    // model: one outstanding memory transaction plus one held response per port
    bit          m_busy, m_owner, m_last;
    int          m_age, m_lat;
    logic [31:0] m_rdata, c_addr, c_wdata;
    logic        c_we;
    logic [3:0]  c_be;
    bit          v[2];
    logic [31:0] la[2], ld[2];
    logic        lw[2];
    bit          fixed, force_done;
    int          fix_lat;
    logic [31:0] fix_data;

    function automatic bit match(int p);
        if (p == 0) return bus.instruction_fetch_activate && bus.instruction_addr == la[0];
        return bus.data_access_activate && bus.data_addr == la[1] && bus.data_write_enable == lw[1];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 0; m_age = 0; m_lat = 1; m_rdata = '0;
        c_addr = '0; c_wdata = '0; c_we = 0; c_be = '0;
        for (int p = 0; p < 2; p++) begin v[p] = 0; la[p] = '0; ld[p] = '0; lw[p] = 0; end
    endtask

    task automatic drive_mem();
        if (rst) bus.mem_done = 1'b0;
        else if (m_busy) begin
            bus.mem_done = (m_age + 1 >= m_lat);
            bus.mem_read_data = m_rdata;
        end else begin
            bus.mem_done = force_done || (!fixed && $urandom_range(7) == 0);
            bus.mem_read_data = $urandom;
        end
    endtask

    task automatic compare();
        bit d0, d1;
        d0 = v[0] && match(0);
        d1 = v[1] && match(1);
        chk("mem_request", 32'(bus.mem_request), 32'(m_busy));
        chk("mem_addr", bus.mem_addr, c_addr);
        chk("mem_write_data", bus.mem_write_data, c_wdata);
        chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(c_we));
        chk("mem_byte_enable", 32'(bus.mem_byte_enable), 32'(c_be));
        chk("instruction_fetch_done", 32'(bus.instruction_fetch_done), 32'(d0));
        chk("data_access_done", 32'(bus.data_access_done), 32'(d1));
        if (d0) chk("instruction_data", bus.instruction_data, ld[0]);
        if (d1 && !lw[1]) chk("data_read_data", bus.data_read_data, ld[1]);
    endtask

    task automatic model_update();
        bit mt[2], pend[2], cap, g;
        if (rst) begin model_reset(); return; end
        for (int p = 0; p < 2; p++) begin
            mt[p] = match(p);
            pend[p] = (p == 0 ? bus.instruction_fetch_activate : bus.data_access_activate) && !(v[p] && mt[p]);
        end
        cap = m_busy && bus.mem_done;
        for (int p = 0; p < 2; p++) begin
            if (cap && int'(m_owner) == p && mt[p]) ld[p] = bus.mem_read_data;
            v[p] = (cap && int'(m_owner) == p) ? mt[p] : v[p] && mt[p];
        end
        if (m_busy) begin
            m_age++;
            if (bus.mem_done) m_busy = 0;
        end else if (pend[0] || pend[1]) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            g = pend[1] && (!pend[0] || !m_last);
`else
            g = pend[1];
`endif
            m_busy = 1; m_owner = g; m_last = g; m_age = 0;
            m_lat = fixed ? fix_lat : int'($urandom_range(3, 1));
            m_rdata = fixed ? fix_data : $urandom;
            c_addr = g ? bus.data_addr : bus.instruction_addr;
            c_wdata = g ? bus.data_write_data : '0;
            c_we = g && bus.data_write_enable;
            c_be = g ? bus.data_byte_enable : '0;
            la[g] = c_addr;
            lw[g] = c_we;
        end
    endtask

    task automatic step();
        drive_mem();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.instruction_addr = '0; bus.instruction_fetch_activate = 0;
        bus.data_addr = '0; bus.data_write_data = '0; bus.data_write_enable = 0;
        bus.data_byte_enable = '0; bus.data_access_activate = 0;
        bus.mem_read_data = '0; bus.mem_done = 0;
        fixed = 1; fix_lat = 1; fix_data = 32'hDEADBEEF; force_done = 0;
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        steps(2);
        chk("rst_mem_request", 32'(bus.mem_request), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_fetch_done", 32'(bus.instruction_fetch_done), 0);
        chk("rst_data_done", 32'(bus.data_access_done), 0);
        chk("rst_instr_data", bus.instruction_data, 0);
        chk("rst_data_rdata", bus.data_read_data, 0);
        rst = 0;
        // fetch 0x100, 1-cycle memory
        bus.instruction_fetch_activate = 1; bus.instruction_addr = 32'h100;
        step();
        chk("t1_req", 32'(bus.mem_request), 1);
        chk("t1_addr", bus.mem_addr, 32'h100);
        step();
        chk("t1_done", 32'(bus.instruction_fetch_done), 1);
        chk("t1_data", bus.instruction_data, 32'hDEADBEEF);
        steps(2);
        chk("t1_hold", 32'(bus.instruction_fetch_done), 1);
        bus.instruction_addr = 32'h104;
        #1;
        chk("t1_clear", 32'(bus.instruction_fetch_done), 0);
        steps(2);
        bus.instruction_fetch_activate = 0;
        steps(2);
        // simultaneous fetch and load
        bus.instruction_fetch_activate = 1; bus.instruction_addr = 32'h200;
        bus.data_access_activate = 1; bus.data_addr = 32'h8000; bus.data_write_enable = 0; bus.data_byte_enable = 4'hF;
        step();
        chk("t2_first", bus.mem_addr, 32'h8000);
        step();
        chk("t2_idle", 32'(bus.mem_request), 0);
        chk("t2_ddone", 32'(bus.data_access_done), 1);
        step();
        chk("t2_second", bus.mem_addr, 32'h200);
        step();
        bus.instruction_fetch_activate = 0; bus.data_access_activate = 0;
        step();
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        bus.data_access_activate = 1; bus.data_addr = 32'h8004;
        steps(2);
        bus.data_access_activate = 0;
        step();
        bus.instruction_fetch_activate = 1; bus.instruction_addr = 32'h204;
        bus.data_access_activate = 1; bus.data_addr = 32'h8008;
        step();
        chk("t2_rr_first", bus.mem_addr, 32'h204);
        steps(4);
        bus.instruction_fetch_activate = 0; bus.data_access_activate = 0;
        step();
`endif
        // withdrawal mid-flight
        fix_lat = 3;
        bus.instruction_fetch_activate = 1; bus.instruction_addr = 32'h300;
        step();
        chk("t3_addr", bus.mem_addr, 32'h300);
        bus.instruction_addr = 32'h400;
        steps(3);
        chk("t3_idle", 32'(bus.mem_request), 0);
        chk("t3_nodone", 32'(bus.instruction_fetch_done), 0);
        step();
        chk("t3_reissue", bus.mem_addr, 32'h400);
        steps(3);
        chk("t3_done", 32'(bus.instruction_fetch_done), 1);
        bus.instruction_fetch_activate = 0;
        step();
        // store
        fix_lat = 1;
        bus.data_access_activate = 1; bus.data_addr = 32'h40; bus.data_write_data = 32'h10;
        bus.data_write_enable = 1; bus.data_byte_enable = 4'b0011;
        step();
        chk("t4_we", 32'(bus.mem_write_enable), 1);
        chk("t4_be", 32'(bus.mem_byte_enable), 32'h3);
        chk("t4_wdata", bus.mem_write_data, 32'h10);
        step();
        chk("t4_done", 32'(bus.data_access_done), 1);
        steps(2);
        chk("t4_hold", 32'(bus.data_access_done), 1);
        bus.data_access_activate = 0;
        #1;
        chk("t4_drop", 32'(bus.data_access_done), 0);
        step();
        // reset while BUSY_DATA
        fix_lat = 3;
        bus.data_access_activate = 1; bus.data_addr = 32'h50; bus.data_write_enable = 0; bus.data_byte_enable = 4'hF;
        step();
        chk("t5_busy", 32'(bus.mem_request), 1);
        rst = 1;
        step();
        chk("t5_req", 32'(bus.mem_request), 0);
        chk("t5_idone", 32'(bus.instruction_fetch_done), 0);
        chk("t5_ddone", 32'(bus.data_access_done), 0);
        rst = 0; bus.data_access_activate = 0; fix_lat = 1;
        bus.instruction_fetch_activate = 1; bus.instruction_addr = 32'h500;
        steps(2);
        chk("t5_fetch", 32'(bus.instruction_fetch_done), 1);
        chk("t5_data", bus.instruction_data, 32'hDEADBEEF);
        bus.instruction_fetch_activate = 0;
        step();
        // stray mem_done while idle
        force_done = 1;
        step();
        force_done = 0;
        chk("t6_req", 32'(bus.mem_request), 0);
        chk("t6_idone", 32'(bus.instruction_fetch_done), 0);
        chk("t6_ddone", 32'(bus.data_access_done), 0);
        chk("t6_data", bus.instruction_data, 32'hDEADBEEF);
        step();
        // randomized traffic
        fixed = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(499) == 0);
            if (!bus.instruction_fetch_activate) begin
                if ($urandom_range(2) == 0) begin
                    bus.instruction_fetch_activate = 1;
                    bus.instruction_addr = 32'h1000 + 4 * $urandom_range(3);
                end
            end else if (v[0] && match(0)) begin
                if ($urandom_range(1) == 0) bus.instruction_fetch_activate = 0;
                else bus.instruction_addr = 32'h1000 + 4 * $urandom_range(3);
            end else if ($urandom_range(15) == 0) bus.instruction_addr = 32'h1000 + 4 * $urandom_range(3);
            if (!bus.data_access_activate) begin
                if ($urandom_range(2) == 0) begin
                    bus.data_access_activate = 1;
                    bus.data_addr = 32'h2000 + 4 * $urandom_range(3);
                    bus.data_write_enable = $urandom_range(1) == 1;
                    bus.data_write_data = $urandom;
                    bus.data_byte_enable = 4'($urandom_range(15));
                end
            end else if (v[1] && match(1)) begin
                if ($urandom_range(1) == 0) bus.data_access_activate = 0;
                else bus.data_addr = 32'h2000 + 4 * $urandom_range(3);
            end else if ($urandom_range(15) == 0) bus.data_write_enable = !bus.data_write_enable;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
